keypad_scan_encoder: RTL and testbench
======================================

Name: keypad_scan_encoder

Overview:
Upstream stage of the 4-bit key register. Scans a 4x4 active-low key matrix, synchronizes and debounces the row inputs, and encodes the pressed key as a 4-bit code. Key_code drives the register's Din and Key_valid drives its Ce, so exactly one register load happens per debounced key press.

Parameters:
SCAN_DIV, 4, clock cycles each column is driven; legal range 4..65535.
DEBOUNCE_SCANS, 3, consecutive identical frames required for a result to count as stable; legal range 1..255.
REPEAT_FRAMES, 8, frames between repeat pulses; used only with KEYPAD_AUTOREPEAT_EN.

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
Row  input  4  matrix rows, active-low, externally pulled up
Col  output 4  matrix column drive, one-hot active-low
Key_code  output 4  encoded key, col*4+row; goes to register Din
Key_valid  output 1  one-cycle load strobe; goes to register Ce
Key_held  output 1  high while the debounced key is pressed

Behaviour:
- Reset values, applied on any CLK edge with RST=1: Col=4'b1110, Key_code=0, Key_valid=0, Key_held=0, synchronizer=4'b1111, all counters=0, FSM=IDLE, previous frame result=NONE.
- Row passes through a 2-flop synchronizer. Only the synchronized value is used.
- Column slot: Col drives column c (bit c low) for SCAN_DIV cycles. The sequence is c=0,1,2,3,0... One frame = 4*SCAN_DIV cycles.
- Sampling: synchronized Row is sampled on the last cycle of each slot. The lowest-index low row r found in column c becomes a candidate code c*4+r.
- Frame result: the lowest candidate code in the frame, or NONE if no row was low. With multiple keys pressed, the lowest code wins.
- Stability counter, updated at the end of each frame:
  - if the frame result equals the previous frame result, increment, saturating at DEBOUNCE_SCANS;
  - otherwise, set to 1.
  - A result is stable when the counter equals DEBOUNCE_SCANS.
- FSM is evaluated on the cycle after frame end:
  - IDLE: on a stable key K, register Key_code=K, pulse Key_valid for 1 cycle, set Key_held=1, go to HELD.
  - HELD: on a stable NONE, clear Key_held and go to IDLE. Key_code keeps its last value. A different stable key while in HELD is ignored; no pulse is issued until after release.
- Latency: Key_valid asserts exactly 1 cycle after the end of the frame in which the counter reaches DEBOUNCE_SCANS.
- Key_valid is never high on two consecutive cycles.
- Key_code changes only in the cycle Key_valid rises.
- Reset mid-operation: all state returns to reset values. A key still held after reset must satisfy debounce again from scratch before it produces a pulse.
- DEBOUNCE_SCANS=1: a single frame is enough to count as stable.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: a frame counter runs while in HELD. Every REPEAT_FRAMES frames with the same stable key, Key_valid pulses again with an unchanged Key_code. The counter clears on entry to HELD and on release.
- Undefined: the frame counter is not built. There is one pulse per press.

Test Plan:
- Reset, then idle with Row=4'b1111 -> Col steps 1110, 1101, 1011, 0111 every 4 cycles and repeats every 16 cycles; Key_valid stays 0 for 10 frames.
- Row=4'b1101 whenever Col=4'b1011, held for 6 frames -> exactly one Key_valid pulse with Key_code=4'd9, 1 cycle after the end of frame 3; Key_held=1 until release.
- Key 9 toggled on/off every frame for 8 frames -> no Key_valid pulse, Key_held=0.
- Keys 9 and 3 pressed together -> single pulse with Key_code=4'd3. Then keys released for 3 frames and key 9 pressed -> second pulse with Key_code=4'd9.
- RST=1 for 1 cycle during a held key 9 -> outputs return to reset values; the next pulse (code 9) comes 3 full frames after reset.
- KEYPAD_AUTOREPEAT_EN defined, REPEAT_FRAMES=4, key 5 held for 20 frames -> first pulse after debounce, then a pulse every 4 frames, all with Key_code=4'd5.

Source files
------------

// File: rtl/keypad_scan_encoder.sv
// 4x4 active-low keypad scanner: column drive, row sync, debounce, key encode.
// Optional KEYPAD_AUTOREPEAT_EN adds periodic repeat pulses while a key is held.
module keypad_scan_encoder #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_FRAMES  = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] Key_code,
  output logic       Key_valid,
  output logic       Key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DB_C = CW'(DEBOUNCE_SCANS);
  // results are {none, code}; 5'h10 means no key in the frame
  localparam logic [4:0] NONE = 5'h10;

  typedef enum logic {IDLE, HELD} state_t;

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx;
  logic [4:0]    best, cand, frame_res, prev_res;
  logic [CW-1:0] stab_cnt, stab_nxt;
  logic          slot_end, frame_end, stable;
  state_t        state;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] rep_cnt;
`endif

  assign slot_end  = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (col_idx == 2'd3);

  // downward loop so the lowest low row is the last assignment
  always_comb begin
    cand = NONE;
    for (int r = 3; r >= 0; r--)
      if (!row_s2[r]) cand = {1'b0, col_idx, 2'(r)};
  end

  // columns scan in ascending order, so the first hit in a frame is the lowest code
  assign frame_res = best[4] ? cand : best;

  always_comb begin
    stab_nxt = CW'(1);
    if (frame_res == prev_res)
      stab_nxt = (stab_cnt == DB_C) ? stab_cnt : stab_cnt + CW'(1);
  end
  assign stable = (stab_nxt == DB_C);

  // FSM acts on the frame-end edge, so Key_valid is high in the first cycle of the next frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_s1    <= 4'b1111;
      row_s2    <= 4'b1111;
      div_cnt   <= '0;
      col_idx   <= 2'd0;
      Col       <= 4'b1110;
      best      <= NONE;
      prev_res  <= NONE;
      stab_cnt  <= '0;
      state     <= IDLE;
      Key_code  <= 4'd0;
      Key_valid <= 1'b0;
      Key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      row_s1    <= Row;
      row_s2    <= row_s1;
      Key_valid <= 1'b0;
      if (slot_end) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        Col     <= ~(4'b0001 << (col_idx + 2'd1));
        best    <= frame_end ? NONE : frame_res;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      if (frame_end) begin
        prev_res <= frame_res;
        stab_cnt <= stab_nxt;
        case (state)
          IDLE: begin
            if (stable && !frame_res[4]) begin
              Key_code  <= frame_res[3:0];
              Key_valid <= 1'b1;
              Key_held  <= 1'b1;
              state     <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt   <= '0;
`endif
            end
          end
          HELD: begin
            if (stable && frame_res[4]) begin
              Key_held <= 1'b0;
              state    <= IDLE;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt  <= '0;
            end else if (stable && frame_res[3:0] == Key_code) begin
              if (rep_cnt == RW'(REPEAT_FRAMES - 1)) begin
                Key_valid <= 1'b1;
                rep_cnt   <= '0;
              end else begin
                rep_cnt <= rep_cnt + RW'(1);
              end
            end else begin
              rep_cnt <= '0;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder: per-cycle frame-level model plus literal pulse checks.
module tb_keypad_scan_encoder;
  localparam int SD = 4, DB = 3, RF = 4, FR = 4 * SD;

  logic        CLK = 1'b0, RST = 1'b1;
  logic [3:0]  Row, Col, Key_code;
  logic        Key_valid, Key_held;
  logic [15:0] mask = '0;

  int cyc = 0, errors = 0, checks = 0;
  int pulse_cnt = 0, pulse_cyc = -1, p0 = 0;
  logic [3:0] pulse_code = '0;

  logic [3:0] exp_col = 4'b1110, exp_code = 4'd0;
  logic       exp_valid = 1'b0, exp_held = 1'b0;
  int m_prev = 16, m_cnt = 0, m_rep = 0, res = 16;
  bit m_held = 1'b0;

  keypad_scan_encoder #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_FRAMES(RF)) dut (
    .CLK(CLK), .RST(RST), .Row(Row), .Col(Col),
    .Key_code(Key_code), .Key_valid(Key_valid), .Key_held(Key_held)
  );

  always #5 CLK = ~CLK;

  // key (c,r) pressed pulls row r low while column c is driven
  always_comb begin
    Row = 4'b1111;
    for (int c = 0; c < 4; c++)
      if (Col[c] == 1'b0)
        for (int r = 0; r < 4; r++)
          if (mask[c*4+r]) Row[r] = 1'b0;
  end

  always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // compare this cycle, then advance the frame-level model to the next cycle
  always @(negedge CLK) begin
    check("col", 32'(Col), 32'(exp_col));
    check("key_valid", 32'(Key_valid), 32'(exp_valid));
    check("key_code", 32'(Key_code), 32'(exp_code));
    check("key_held", 32'(Key_held), 32'(exp_held));
    if (Key_valid === 1'b1) begin
      pulse_cnt++;
      pulse_cyc  = cyc;
      pulse_code = Key_code;
    end
    exp_valid = 1'b0;
    if (RST) begin
      exp_col = 4'b1110; exp_code = 4'd0; exp_held = 1'b0;
      m_prev = 16; m_cnt = 0; m_rep = 0; m_held = 1'b0;
    end else begin
      exp_col = 4'b1111;
      exp_col[((cyc + 1) / SD) % 4] = 1'b0;
      if (cyc % FR == FR - 1) begin
        res = 16;
        for (int k = 15; k >= 0; k--) if (mask[k]) res = k;
        m_cnt  = (res == m_prev) ? ((m_cnt < DB) ? m_cnt + 1 : DB) : 1;
        m_prev = res;
        if (!m_held) begin
          if (m_cnt == DB && res < 16) begin
            exp_valid = 1'b1; exp_code = 4'(res); m_held = 1'b1; m_rep = 0;
          end
        end else if (m_cnt == DB && res == 16) begin
          m_held = 1'b0; m_rep = 0;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          if (m_cnt == DB && res == int'(exp_code)) begin
            m_rep++;
            if (m_rep == RF) begin exp_valid = 1'b1; m_rep = 0; end
          end else m_rep = 0;
`endif
        end
        exp_held = m_held;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge CLK); #2; end
  endtask

  task automatic frames(input int n, input logic [15:0] m);
    while (cyc % FR != 0) step(1);
    mask = m;
    step(n * FR);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    p0 = pulse_cnt;
  endtask

  initial begin
    step(2);
    // idle scan
    do_reset();
    check("rst_col", 32'(Col), 32'h0000000e);
    check("rst_held", 32'(Key_held), 32'd0);
    check("rst_code", 32'(Key_code), 32'd0);
    step(4);
    check("col_slot1", 32'(Col), 32'h0000000d);
    frames(10, 16'h0000);
    check("idle_pulses", 32'(pulse_cnt - p0), 32'd0);

    // key 9 held six frames, then released
    do_reset();
    frames(6, 16'h0200);
    check("k9_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("k9_pulse_cyc", 32'(pulse_cyc), 32'd48);
    check("k9_code", 32'(pulse_code), 32'd9);
    check("k9_held", 32'(Key_held), 32'd1);
    frames(3, 16'h0000);
    check("k9_released", 32'(Key_held), 32'd0);
    check("k9_code_kept", 32'(Key_code), 32'd9);

    // bouncing key never settles
    do_reset();
    for (int i = 0; i < 8; i++) frames(1, (i % 2 == 0) ? 16'h0200 : 16'h0000);
    check("bounce_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("bounce_held", 32'(Key_held), 32'd0);

    // two keys: lowest code wins, then a new press after release
    do_reset();
    frames(4, 16'h0208);
    check("multi_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("multi_code", 32'(pulse_code), 32'd3);
    frames(3, 16'h0000);
    frames(4, 16'h0200);
    check("second_pulses", 32'(pulse_cnt - p0), 32'd2);
    check("second_code", 32'(pulse_code), 32'd9);
    check("second_cyc", 32'(pulse_cyc), 32'd160);

    // reset while key 9 is held: debounce restarts from scratch
    do_reset();
    frames(4, 16'h0200);
    step(6);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    check("midrst_held", 32'(Key_held), 32'd0);
    check("midrst_code", 32'(Key_code), 32'd0);
    check("midrst_col", 32'(Col), 32'h0000000e);
    p0 = pulse_cnt;
    step(4 * FR);
    check("midrst_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("midrst_cyc", 32'(pulse_cyc), 32'd48);

    // key 5 held for 20 frames
    do_reset();
    frames(20, 16'h0020);
    check("k5_code", 32'(pulse_code), 32'd5);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("k5_pulses", 32'(pulse_cnt - p0), 32'd5);
    check("k5_last_cyc", 32'(pulse_cyc), 32'd304);
`else
    check("k5_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("k5_last_cyc", 32'(pulse_cyc), 32'd48);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
